// File: rtl/pixel_serializer.sv
// Serial transmitter for the pixel bit-timing link: start bit, DATA_W data bits sent
// LSB first, then a stop bit. The bit timer advances only on cycles where i_enable is high.
module pixel_serializer #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned TICKS_PER_BIT = 8
) (
  input  logic              i_clk,
  input  logic              i_n_rst,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_serial_out,
  output logic              o_busy,
  output logic              o_tx_done
);

  localparam int unsigned TickW = $clog2(TICKS_PER_BIT);
  localparam int unsigned IdxW  = $clog2(DATA_W) + 1;

  localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e              r_state;
  logic [TickW-1:0]    r_tick_cnt;
  logic [IdxW-1:0]     r_bit_idx;
  logic [DATA_W-1:0]   r_shift_reg;
  logic                r_serial_out;
  logic                r_busy;
  logic                r_tx_done;

  state_e              w_state_d;
  logic [TickW-1:0]    w_tick_d;
  logic [IdxW-1:0]     w_idx_d;
  logic [DATA_W-1:0]   w_shift_d;
  logic                w_serial_d;
  logic                w_busy_d;
  logic                w_done_d;

  logic                w_bit_end;
  logic [DATA_W-1:0]   w_shift_nxt;

  assign w_bit_end   = (r_tick_cnt == TickLast);
  assign w_shift_nxt = r_shift_reg >> 1;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state      <= StIdle;
      r_tick_cnt   <= '0;
      r_bit_idx    <= '0;
      r_shift_reg  <= '0;
      r_serial_out <= 1'b1;
      r_busy       <= 1'b0;
      r_tx_done    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_tick_cnt   <= w_tick_d;
      r_bit_idx    <= w_idx_d;
      r_shift_reg  <= w_shift_d;
      r_serial_out <= w_serial_d;
      r_busy       <= w_busy_d;
      r_tx_done    <= w_done_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_tick_d   = r_tick_cnt;
    w_idx_d    = r_bit_idx;
    w_shift_d  = r_shift_reg;
    w_serial_d = r_serial_out;
    w_busy_d   = r_busy;
    // The done pulse lasts a single clock even when the following cycle is disabled.
    w_done_d   = 1'b0;

    if (i_enable) begin
      unique case (r_state)
        StIdle: begin
          w_serial_d = 1'b1;
          if (i_tx_valid) begin
            w_shift_d  = i_tx_data;
            w_tick_d   = '0;
            w_idx_d    = '0;
            w_serial_d = 1'b0;
            w_busy_d   = 1'b1;
            w_state_d  = StStart;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            w_tick_d   = '0;
            w_serial_d = r_shift_reg[0];
            w_state_d  = StData;
          end else begin
            w_tick_d = r_tick_cnt + TickW'(1);
          end
        end
        StData: begin
          if (w_bit_end) begin
            w_tick_d  = '0;
            w_shift_d = w_shift_nxt;
            w_idx_d   = r_bit_idx + IdxW'(1);
            if (r_bit_idx == IdxLast) begin
              w_serial_d = 1'b1;
              w_state_d  = StStop;
            end else begin
              w_serial_d = w_shift_nxt[0];
            end
          end else begin
            w_tick_d = r_tick_cnt + TickW'(1);
          end
        end
        StStop: begin
          if (w_bit_end) begin
            w_tick_d  = '0;
            w_idx_d   = '0;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_tick_d = r_tick_cnt + TickW'(1);
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  assign o_tx_ready   = (r_state == StIdle);
  assign o_serial_out = r_serial_out;
  assign o_busy       = r_busy;
  assign o_tx_done    = r_tx_done;

endmodule

// File: tb/tb_pixel_serializer.sv
// Scoreboard bench for pixel_serializer: the driver queues each expected frame when the
// word is accepted, and a line monitor decodes serial_out by counting enabled cycles.
module tb_pixel_serializer;

  localparam int unsigned DW  = 8;
  localparam int unsigned TPB = 8;

  logic          clk      = 1'b0;
  logic          n_rst    = 1'b1;
  logic          enable   = 1'b1;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data  = '0;
  logic          tx_ready;
  logic          serial_out;
  logic          busy;
  logic          tx_done;

  pixel_serializer #(
    .DATA_W       (DW),
    .TICKS_PER_BIT(TPB)
  ) u_dut (
    .i_clk       (clk),
    .i_n_rst     (n_rst),
    .i_enable    (enable),
    .i_tx_data   (tx_data),
    .i_tx_valid  (tx_valid),
    .o_tx_ready  (tx_ready),
    .o_serial_out(serial_out),
    .o_busy      (busy),
    .o_tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  // len/gap of 0 mean "do not check"
  typedef struct {
    logic [DW-1:0] data;
    int            len;
    int            gap;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic gate_mode = 1'b0;
  int   gate_cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change at posedge+3; enable low for 3 cycles out of every 8 in gated mode.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (gate_mode) begin
        enable   = ((gate_cyc % 8) >= 3);
        gate_cyc = gate_cyc + 1;
      end else begin
        enable = 1'b1;
      end
    end
  end

  // Line monitor, sampled on negedge: enable seen here is the value used at the next edge.
  logic          m_act  = 1'b0;
  logic          m_pend = 1'b0;
  logic          m_have;
  logic          m_val;
  logic          m_bad;
  logic [DW+1:0] m_bits;
  int            m_bitn;
  int            m_cnt;
  int            m_clen;
  int            m_gap  = 0;
  exp_t          m_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        m_act  = 1'b0;
        m_pend = 1'b0;
        m_gap  = 0;
      end else begin
        if (m_pend) begin
          chk("tx_done_pulse", 32'(tx_done), 32'd1);
          chk("busy_cleared", 32'(busy), 32'd0);
          chk("ready_on_done", 32'(tx_ready), 32'd1);
          m_pend = 1'b0;
        end else if (!m_act) begin
          chk("idle_done_low", 32'(tx_done), 32'd0);
        end
        if (!m_act) begin
          if (serial_out === 1'b0) begin
            m_act  = 1'b1;
            m_bitn = 0;
            m_cnt  = 0;
            m_clen = 0;
            m_have = 1'b0;
            m_bad  = 1'b0;
            m_bits = '0;
            chk("frame_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0 && q[0].gap > 0) chk("idle_gap", 32'(m_gap), 32'(q[0].gap));
          end else begin
            m_gap = m_gap + 1;
          end
        end
        if (m_act) begin
          m_clen = m_clen + 1;
          if (!m_have) begin
            m_val  = serial_out;
            m_have = 1'b1;
          end else if (serial_out !== m_val) begin
            m_bad = 1'b1;
          end
          if (busy !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b0) m_bad = 1'b1;
          if (enable) m_cnt = m_cnt + 1;
          if (m_cnt == TPB) begin
            m_bits[m_bitn] = m_val;
            m_bitn = m_bitn + 1;
            m_cnt  = 0;
            m_have = 1'b0;
            if (m_bitn == DW + 2) begin
              m_act  = 1'b0;
              m_pend = 1'b1;
              m_gap  = 0;
              chk("frame_queued", 32'(q.size() != 0), 32'd1);
              if (q.size() != 0) begin
                m_e = q.pop_front();
                chk("start_bit", 32'(m_bits[0]), 32'd0);
                chk("stop_bit", 32'(m_bits[DW+1]), 32'd1);
                chk("data_bits", 32'(m_bits[DW:1]), 32'(m_e.data));
                chk("bit_stable_busy", 32'(m_bad), 32'd0);
                if (m_e.len > 0) chk("frame_clks", 32'(m_clen), 32'(m_e.len));
              end
            end
          end
        end
      end
    end
  end

  // Enter and leave at posedge+3.
  task automatic send(input logic [DW-1:0] d, input int len, input int gap, input bit keep);
    bit   ok;
    exp_t e;
    ok       = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1 && enable === 1'b1) ok = 1'b1;
    end
    chk("accepted", 32'(ok), 32'd1);
    if (ok) begin
      e.data = d;
      e.len  = len;
      e.gap  = gap;
      q.push_back(e);
    end
    @(posedge clk);
    #3;
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !m_act && !m_pend) ok = 1'b1;
    end
    chk("drain", 32'(ok), 32'd1);
    @(posedge clk);
    #3;
  endtask

  task automatic check_quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("line_quiet", 32'(serial_out), 32'd1);
    end
    @(posedge clk);
    #3;
  endtask

  initial begin
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_serial", 32'(serial_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    n_rst = 1'b1;
    check_quiet(10);

    // Single frame 0xA5: 80 clocks, bits 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 80, 0, 1'b0);
    wait_idle();

    // Back-to-back with tx_valid held: one idle-high cycle between frames
    send(8'h00, 80, 0, 1'b1);
    send(8'hFF, 80, 1, 1'b0);
    wait_idle();

    // Enable gating stretches bits but keeps content
    gate_mode = 1'b1;
    send(8'h3C, 0, 0, 1'b0);
    wait_idle();
    gate_mode = 1'b0;
    @(posedge clk);
    #3;

    // Word presented while busy is held off until the first idle cycle
    send(8'hC3, 80, 0, 1'b0);
    repeat (20) @(posedge clk);
    #3;
    send(8'h11, 80, 1, 1'b0);
    wait_idle();

    // Reset in the middle of data bit 4 of 0x5A
    send(8'h5A, 0, 0, 1'b0);
    repeat (43) @(posedge clk);
    #3;
    n_rst = 1'b0;
    q.delete();
    #1;
    chk("midrst_serial", 32'(serial_out), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(tx_done), 32'd0);
    chk("midrst_ready", 32'(tx_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    n_rst = 1'b1;
    check_quiet(20);
    send(8'h81, 80, 0, 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
